shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a long shift/rotate through an external
// combinational shifter that can move at most MAX_STEP positions per pass.
//
// Handshake: start is a one-cycle request that is sampled only while idle
// (busy low); requests raised while busy are dropped, not queued. done is a
// single-cycle pulse, and result_out/carry_out are valid from that pulse
// until the next done.
//
// Timing: the edge that accepts start is cycle 0. Each RUN cycle performs one
// shifter pass. The DONE cycle copies the final work value and carry to the
// outputs, so done is seen ceil(count/MAX_STEP)+1 cycles after acceptance
// (1 cycle when count_in is 0).
module shift_seq_ctrl #(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [4:0] count_in,
  input  logic [1:0] op_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_out,
  output logic       carry_out,
  output logic [2:0] sh_count,
  output logic [7:0] sh_data,
  output logic [1:0] sh_op,
  input  logic [7:0] sh_result,
  input  logic       sh_c,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [4:0] MAX_STEP_W = 5'(MAX_STEP);

  state_e     state_q;
  logic [7:0] work_q;
  logic [1:0] op_q;
  logic [4:0] remaining_q;
  logic       carry_q;
  logic [7:0] result_q;
  logic       cout_q;
  logic       busy_q;
  logic       done_q;

  logic [2:0] step_d;
  logic [4:0] remaining_d;

  // Per-pass distance: never more than what is left, so remaining cannot wrap.
  always_comb begin
    step_d = 3'd0;
    if (state_q == S_RUN) begin
      if (remaining_q < MAX_STEP_W) begin
        step_d = remaining_q[2:0];
      end else begin
        step_d = MAX_STEP_W[2:0];
      end
    end
    remaining_d = remaining_q - {2'b00, step_d};
  end

  // Control FSM plus all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      work_q      <= 8'h00;
      op_q        <= 2'b00;
      remaining_q <= 5'd0;
      carry_q     <= 1'b0;
      result_q    <= 8'h00;
      cout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            work_q      <= data_in;
            op_q        <= op_in;
            remaining_q <= count_in;
            carry_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (count_in == 5'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          work_q      <= sh_result;
          carry_q     <= sh_c;
          remaining_q <= remaining_d;
          if (remaining_d == 5'd0) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          result_q <= work_q;
          cout_q   <= carry_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sh_count   = step_d;
  assign sh_data    = work_q;
  assign sh_op      = op_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = result_q;
  assign carry_out  = cout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a combinational shift/rotate unit is attached to
// the sh_* ports, and every operation is checked against a whole-distance
// reference computed directly from the total shift count.
module tb_shift_seq_ctrl;

  localparam int MAX_STEP = 7;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [4:0] count_in = 5'd0;
  logic [1:0] op_in = 2'b00;
  logic       busy, done, carry_out;
  logic [7:0] result_out, sh_data, sh_result;
  logic [2:0] sh_count;
  logic [1:0] sh_op, dbg_state;
  logic       sh_c;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.MAX_STEP(MAX_STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .count_in   (count_in),
    .op_in      (op_in),
    .busy       (busy),
    .done       (done),
    .result_out (result_out),
    .carry_out  (carry_out),
    .sh_count   (sh_count),
    .sh_data    (sh_data),
    .sh_op      (sh_op),
    .sh_result  (sh_result),
    .sh_c       (sh_c),
    .dbg_state  (dbg_state)
  );

  // Single-pass shift/rotate unit; carry is the last bit shifted out.
  logic [15:0] sh_tmp;
  always_comb begin
    sh_tmp    = 16'h0000;
    sh_result = sh_data;
    sh_c      = 1'b0;
    case (sh_op)
      2'b00: begin
        sh_tmp    = {8'h00, sh_data} << sh_count;
        sh_result = sh_tmp[7:0];
        sh_c      = sh_tmp[8];
      end
      2'b01: begin
        sh_tmp    = {sh_data, 8'h00} >> sh_count;
        sh_result = sh_tmp[15:8];
        sh_c      = sh_tmp[7];
      end
      2'b10: begin
        sh_tmp    = {sh_data, sh_data} << sh_count;
        sh_result = sh_tmp[15:8];
        sh_c      = (sh_count != 3'd0) ? sh_tmp[8] : 1'b0;
      end
      default: begin
        sh_tmp    = {sh_data, sh_data} >> sh_count;
        sh_result = sh_tmp[7:0];
        sh_c      = (sh_count != 3'd0) ? sh_tmp[7] : 1'b0;
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} of shifting d by the full distance c at once.
  function automatic logic [8:0] model(input logic [7:0] d, input int c, input logic [1:0] op);
    longint x, res, cy;
    int r;
    x = longint'(d);
    if (c == 0) return {1'b0, d};
    r = c % 8;
    case (op)
      2'b00: begin res = (x << c) & 255; cy = ((x << c) >> 8) & 1; end
      2'b01: begin res = x >> c;         cy = ((x << 1) >> c) & 1; end
      2'b10: begin res = ((x << r) | (x >> (8 - r))) & 255; cy = res & 1; end
      default: begin res = ((x >> r) | (x << (8 - r))) & 255; cy = (res >> 7) & 1; end
    endcase
    return {cy[0], res[7:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [7:0] d, input logic [4:0] c, input logic [1:0] op,
                        input bit repulse, input string tag);
    int lat, busy_cyc, exp_lat, extra;
    bit seen, sh_bad;
    logic [8:0] exp_v;
    exp_q.push_back(model(d, int'(c), op));
    exp_lat = (c == 0) ? 1 : (int'(c) + MAX_STEP - 1) / MAX_STEP + 1;
    @(negedge clk);
    start = 1'b1; data_in = d; count_in = c; op_in = op;
    @(posedge clk);
    seen = 0; lat = -1; busy_cyc = 0; sh_bad = 0;
    for (int k = 0; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (sh_count > 3'(MAX_STEP)) sh_bad = 1;
      if (c == 5'd0 && sh_count != 3'd0) sh_bad = 1;
      if (done) begin
        seen = 1;
        lat = k;
      end else if (repulse && busy) begin
        start = 1'b1; data_in = 8'($urandom); count_in = 5'($urandom); op_in = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp_v = exp_q.pop_front();
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
    chk({tag, "_sh_count_range"}, 32'(sh_bad), 32'd0);
    chk({tag, "_result"}, 32'(result_out), 32'(exp_v[7:0]));
    chk({tag, "_carry"}, 32'(carry_out), 32'(exp_v[8]));
    chk({tag, "_sh_data_hold"}, 32'(sh_data), 32'(exp_v[7:0]));
    chk({tag, "_sh_op_hold"}, 32'(sh_op), 32'(op));
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) extra++;
      if (k == 0) chk({tag, "_result_held"}, 32'(result_out), 32'(exp_v[7:0]));
    end
    chk({tag, "_single_done"}, 32'(extra), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] rc;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result_out), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_sh_data", 32'(sh_data), 32'd0);
    chk("rst_sh_op", 32'(sh_op), 32'd0);
    chk("rst_sh_count", 32'(sh_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 5'd2,  2'b00, 0, "shl_05_2");
    chk("shl_05_2_lit", 32'(result_out), 32'h14);
    run_op(8'h81, 5'd8,  2'b00, 0, "shl_81_8");
    chk("shl_81_8_lit", 32'({carry_out, result_out}), 32'h100);
    run_op(8'h4C, 5'd10, 2'b10, 0, "rol_4c_10");
    chk("rol_4c_10_lit", 32'(result_out), 32'h31);
    run_op(8'hA5, 5'd0,  2'b01, 0, "zero_a5");
    chk("zero_a5_lit", 32'({carry_out, result_out}), 32'h0A5);
    run_op(8'h5A, 5'd31, 2'b10, 1, "repulse_31");

    // Reset in the middle of a long operation.
    @(negedge clk);
    start = 1'b1; data_in = 8'hC3; count_in = 5'd31; op_in = 2'b11;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrun_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    chk("midrun_rst_result", 32'(result_out), 32'd0);
    chk("midrun_rst_carry", 32'(carry_out), 32'd0);
    chk("midrun_rst_sh_data", 32'(sh_data), 32'd0);
    chk("midrun_rst_sh_count", 32'(sh_count), 32'd0);
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done) dn++;
      end
      chk("midrun_no_done", 32'(dn), 32'd0);
    end
    rst = 1'b0;
    run_op(8'h80, 5'd3, 2'b01, 0, "shr_80_3");
    chk("shr_80_3_lit", 32'({carry_out, result_out}), 32'h010);

    // Boundary distances for every operation.
    for (int op = 0; op < 4; op++) begin
      run_op(8'($urandom), 5'd7,  2'(op), 0, "edge7");
      run_op(8'($urandom), 5'd8,  2'(op), 0, "edge8");
      run_op(8'($urandom), 5'd1,  2'(op), 0, "edge1");
    end

    // Randomized operations, some with extra start requests while busy.
    for (int i = 0; i < 60; i++) begin
      rc = 5'($urandom_range(0, 31));
      run_op(8'($urandom), rc, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
